ring_output_port_ctrl: RTL and testbench
========================================

Name: ring_output_port_ctrl

Overview:
Controller for one router output channel (CW, CCW or PE) of the ring NoC. Owns the single-entry output buffer and shares it between the two inputs that can target it, using round-robin priority. Drives a valid/ready link to the downstream router or PE. Exposes per-requester grant counters for performance debug.
- Arbitration and link transmission are gated by phase enables from the router's odd/even sequencer.

Parameters:
DATA_W, 64, packet width in bits
INIT_PRIORITY, 1'b0, priority after reset (0 = req0 preferred, 1 = req1 preferred)
CNT_W, 16, width of the saturating grant/contention counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
arb_en  input  1  arbitration phase enable from the router phase sequencer
tx_en  input  1  link transmit phase enable
req0  input  1  requester 0 has a packet for this output
data0  input  DATA_W  requester 0 packet
req1  input  1  requester 1 has a packet for this output
data1  input  DATA_W  requester 1 packet
grant0  output  1  requester 0 won; it pops its input buffer this cycle
grant1  output  1  requester 1 won; it pops its input buffer this cycle
out_valid  output  1  packet offered on link
out_data  output  DATA_W  output buffer contents
out_ready  input  1  downstream can accept
buf_full  output  1  output buffer occupied
grant_cnt0  output  CNT_W  saturating count of grant0
grant_cnt1  output  CNT_W  saturating count of grant1
conflict_cnt  output  CNT_W  saturating count of cycles where both requested and a grant was issued

Behaviour:
- Reset (async, immediate): buf_full=0, out_data=0, priority=INIT_PRIORITY, all counters=0. grant0/grant1/out_valid are 0 while reset is high.
- Arbitration is combinational and only qualified when arb_en=1 and buf_full=0 (registered state; no same-cycle bypass from a drain).
  - Exactly one request: that requester is granted.
  - Both requests: priority=0 grants req0, priority=1 grants req1.
  - Otherwise no grant. grant0 and grant1 are never both 1.
- On the edge after a grant: out_data <= granted data, buf_full <= 1. Latency from grant to out_valid is 1 cycle, subject to tx_en.
- Priority flips only on a contended grant (both requests, grant issued). A single request does not change priority.
- Fairness bound: under persistent contention, grants strictly alternate.
- out_valid = buf_full & tx_en (combinational).
  - Transfer occurs when out_valid & out_ready; buf_full <= 0 on that edge.
  - out_data holds its value until the next capture. It is not cleared on drain.
- Simultaneous arb_en and tx_en with buf_full=1 and a transfer: the drain happens and no grant is issued that cycle. The next grant is possible in the following arb_en cycle.
- out_ready=0 holds the packet indefinitely. out_data and out_valid stay stable while tx_en=1.
- Counters increment by 1 on their event and saturate at all-ones with no wrap. conflict_cnt increments in the same cycle as the contended grant.
- Reset mid-operation discards any buffered packet. A grant asserted in the reset cycle has no effect.

Test Plan:
- Reset then idle: reset=1 then released, no requests -> buf_full=0, out_valid=0, counters 0, grants 0 for 10 cycles.
- Single requester: arb_en=1, req0=1, data0=64'hA5 -> grant0=1 that cycle; next cycle buf_full=1. With tx_en=1 and out_ready=1: out_valid=1, out_data=64'hA5, then buf_full=0. grant_cnt0=1, priority unchanged.
- Contention alternation: req0=req1=1 held, arb_en=1 every cycle, tx_en=1, out_ready=1 -> grant sequence 0,1,0,1 (INIT_PRIORITY=0) on successive arbitration opportunities. conflict_cnt=4 after four grants.
- Backpressure: buffer full, out_ready=0 for 5 cycles with arb_en=1 and both requests -> no grants, out_data stable. out_ready=1 drains. The grant is issued on the next arb_en cycle after the drain, not in the drain cycle.
- Same-cycle arb_en and tx_en: buf_full=1, out_ready=1, req1=1 -> transfer occurs, grant1=0 that cycle, grant1=1 the following cycle.
- Saturation and async reset: CNT_W=4, 20 grants to req1 -> grant_cnt1=4'hF. Assert reset between clock edges with buf_full=1 -> buf_full and counters clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/ring_output_port_ctrl.sv
// Output-channel controller for one ring router port: a single-entry output
// buffer shared by two requesters with round-robin priority, plus perf counters.
module ring_output_port_ctrl #(
  parameter int         DATA_W        = 64,
  parameter logic       INIT_PRIORITY = 1'b0,
  parameter int         CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arb_en,
  input  logic              tx_en,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              grant0,
  output logic              grant1,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              buf_full,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              prio_q, prio_d;
  logic [CNT_W-1:0]  gcnt0_q, gcnt0_d;
  logic [CNT_W-1:0]  gcnt1_q, gcnt1_d;
  logic [CNT_W-1:0]  conf_q, conf_d;

  logic arb_ok, both, g0, g1, xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Arbitration only sees the registered buffer state, so a drain this
  // cycle cannot be refilled until the next arbitration opportunity.
  assign arb_ok = arb_en & ~buf_full_q & ~reset;
  assign both   = req0 & req1;
  assign g0     = arb_ok & req0 & (~req1 | ~prio_q);
  assign g1     = arb_ok & req1 & (~req0 |  prio_q);
  assign xfer   = out_valid & out_ready;

  assign grant0       = g0;
  assign grant1       = g1;
  assign out_valid    = buf_full_q & tx_en & ~reset;
  assign out_data     = data_q;
  assign buf_full     = buf_full_q;
  assign grant_cnt0   = gcnt0_q;
  assign grant_cnt1   = gcnt1_q;
  assign conflict_cnt = conf_q;

  always_comb begin
    buf_full_d = buf_full_q;
    data_d     = data_q;
    prio_d     = prio_q;
    gcnt0_d    = gcnt0_q;
    gcnt1_d    = gcnt1_q;
    conf_d     = conf_q;
    if (g0 | g1) begin
      buf_full_d = 1'b1;
      data_d     = g0 ? data0 : data1;
      if (g0) gcnt0_d = sat_inc(gcnt0_q);
      if (g1) gcnt1_d = sat_inc(gcnt1_q);
      if (both) begin
        prio_d = ~prio_q;
        conf_d = sat_inc(conf_q);
      end
    end else if (xfer) begin
      buf_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full_q <= 1'b0;
      data_q     <= '0;
      prio_q     <= INIT_PRIORITY;
      gcnt0_q    <= '0;
      gcnt1_q    <= '0;
      conf_q     <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      data_q     <= data_d;
      prio_q     <= prio_d;
      gcnt0_q    <= gcnt0_d;
      gcnt1_q    <= gcnt1_d;
      conf_q     <= conf_d;
    end
  end

endmodule

// File: tb/tb_ring_output_port_ctrl.sv
// Directed bench for ring_output_port_ctrl: vector table plus corner sequences.
module tb_ring_output_port_ctrl;

  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          arb_en, tx_en, req0, req1, out_ready;
  logic [DW-1:0] data0, data1;
  logic          grant0, grant1, out_valid, buf_full;
  logic [DW-1:0] out_data;
  logic [CW-1:0] grant_cnt0, grant_cnt1, conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ring_output_port_ctrl #(.DATA_W(DW), .INIT_PRIORITY(1'b0), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .arb_en(arb_en), .tx_en(tx_en),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .grant0(grant0), .grant1(grant1), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .buf_full(buf_full),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
  );

  typedef struct {
    logic          arb, tx, r0, r1, rdy;
    logic [DW-1:0] d0, d1;
    logic          eg0, eg1, eov, ebf;
    logic [DW-1:0] eod;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic arb, tx, r0, r1, rdy,
                              input logic [DW-1:0] d0, d1,
                              input logic eg0, eg1, eov, ebf,
                              input logic [DW-1:0] eod);
    vec_t v;
    v.arb = arb; v.tx = tx; v.r0 = r0; v.r1 = r1; v.rdy = rdy;
    v.d0 = d0; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.eov = eov; v.ebf = ebf; v.eod = eod;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic arb, tx, r0, r1, rdy, input logic [DW-1:0] d0, d1);
    arb_en = arb; tx_en = tx; req0 = r0; req1 = r1; out_ready = rdy;
    data0 = d0; data1 = d1;
  endtask

  // Called just after a negedge: apply, sample, then advance one full cycle.
  task automatic run_vec(input vec_t v, input int idx);
    drive(v.arb, v.tx, v.r0, v.r1, v.rdy, v.d0, v.d1);
    #1;
    chk($sformatf("v%0d.grant0", idx),    {63'b0, grant0},    {63'b0, v.eg0});
    chk($sformatf("v%0d.grant1", idx),    {63'b0, grant1},    {63'b0, v.eg1});
    chk($sformatf("v%0d.out_valid", idx), {63'b0, out_valid}, {63'b0, v.eov});
    chk($sformatf("v%0d.buf_full", idx),  {63'b0, buf_full},  {63'b0, v.ebf});
    chk($sformatf("v%0d.out_data", idx),  out_data,           v.eod);
    @(negedge clk);
  endtask

  task automatic chk_cnts(input string tag, input int c0, input int c1, input int cf);
    chk({tag, ".grant_cnt0"},   {60'b0, grant_cnt0},   DW'(c0));
    chk({tag, ".grant_cnt1"},   {60'b0, grant_cnt1},   DW'(c1));
    chk({tag, ".conflict_cnt"}, {60'b0, conflict_cnt}, DW'(cf));
  endtask

  task automatic idle_check(input string tag, input int n);
    drive(0, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < n; i++) begin
      #1;
      chk({tag, ".buf_full"},  {63'b0, buf_full},  '0);
      chk({tag, ".out_valid"}, {63'b0, out_valid}, '0);
      chk({tag, ".grants"},    {62'b0, grant1, grant0}, '0);
      chk_cnts(tag, 0, 0, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, '0, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle_check("reset_idle", 10);

    // prio=0 out of reset; single req, then contention with full drain each time,
    // then backpressure, then drain-cycle no-grant.
    tbl.push_back(mk(0,0,0,0,0, 0,     0,     0,0,0,0, 0));
    tbl.push_back(mk(1,1,1,0,1, 'hA5,  0,     1,0,0,0, 0));
    tbl.push_back(mk(0,1,0,0,1, 0,     0,     0,0,1,1, 'hA5));
    tbl.push_back(mk(0,0,0,0,0, 0,     0,     0,0,0,0, 'hA5));
    tbl.push_back(mk(1,1,1,1,1, 'h10, 'h11,   1,0,0,0, 'hA5));
    tbl.push_back(mk(1,1,1,1,1, 'h10, 'h11,   0,0,1,1, 'h10));
    tbl.push_back(mk(1,1,1,1,1, 'h10, 'h11,   0,1,0,0, 'h10));
    tbl.push_back(mk(1,1,1,1,1, 'h10, 'h11,   0,0,1,1, 'h11));
    tbl.push_back(mk(1,1,1,1,1, 'h10, 'h11,   1,0,0,0, 'h11));
    tbl.push_back(mk(1,1,1,1,1, 'h10, 'h11,   0,0,1,1, 'h10));
    tbl.push_back(mk(1,1,1,1,1, 'h10, 'h11,   0,1,0,0, 'h10));
    tbl.push_back(mk(1,1,1,1,1, 'h10, 'h11,   0,0,1,1, 'h11));
    tbl.push_back(mk(1,1,1,1,0, 'h20, 'h21,   1,0,0,0, 'h11));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1,1,1,1,0, 'h20, 'h21, 0,0,1,1, 'h20));
    tbl.push_back(mk(1,1,1,1,1, 'h20, 'h21,   0,0,1,1, 'h20));
    tbl.push_back(mk(1,1,1,1,1, 'h20, 'h21,   0,1,0,0, 'h20));
    tbl.push_back(mk(0,1,0,0,1, 0,     0,     0,0,1,1, 'h21));

    foreach (tbl[i]) run_vec(tbl[i], i);
    chk_cnts("after_table", 4, 3, 6);

    // Single request must not flip priority: req0 still wins the next contention.
    run_vec(mk(1,0,0,1,0, 0,     'h33,  0,1,0,0, 'h21), 100);
    run_vec(mk(0,1,0,0,1, 0,     0,     0,0,1,1, 'h33), 101);
    run_vec(mk(1,0,1,1,0, 'h40,  'h41,  1,0,0,0, 'h33), 102);
    run_vec(mk(0,1,0,0,1, 0,     0,     0,0,1,1, 'h40), 103);
    chk_cnts("prio_hold", 5, 4, 7);

    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 1, 0, '0, DW'(i));
      @(negedge clk);
      drive(0, 1, 0, 0, 1, '0, '0);
      @(negedge clk);
    end
    chk_cnts("saturate", 5, 15, 7);
    chk("saturate.out_data", out_data, DW'(19));

    // Fill the buffer, then assert reset mid-cycle with no clock edge involved.
    drive(1, 0, 1, 0, 0, 'hBEEF, '0);
    @(negedge clk);
    drive(1, 1, 1, 0, 0, 'hBEEF, '0);
    #1;
    chk("pre_reset.buf_full", {63'b0, buf_full}, 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset.buf_full",  {63'b0, buf_full},  '0);
    chk("async_reset.out_valid", {63'b0, out_valid}, '0);
    chk("async_reset.out_data",  out_data,           '0);
    chk("async_reset.grant0",    {63'b0, grant0},    '0);
    chk_cnts("async_reset", 0, 0, 0);
    @(negedge clk);
    #1;
    chk("reset_cycle.buf_full", {63'b0, buf_full}, '0);
    chk("reset_cycle.grant0",   {63'b0, grant0},   '0);
    @(negedge clk);
    reset = 1'b0;
    idle_check("post_reset", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  always @(negedge clk) begin
    if (grant0 && grant1) begin
      errors++;
      $display("FAIL dual_grant: got grant0=1 grant1=1 expected at most one at %0t", $time);
    end
  end

endmodule
